multicycle_ctrl: RTL

Multicycle control FSM that sequences the RV32I datapath (PC, IR, immediate generator, ALU, register file, data memory) through fetch, decode, execute, memory and writeback. It handshakes with the instruction and data memories, drives every datapath enable and mux select, and selects the immediate format per opcode. It traps on illegal opcodes and on data-memory timeout, and keeps a retired-instruction counter.

---
 rtl/multicycle_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control FSM
// Sequences fetch/decode/exec/mem/writeback and drives all datapath enables and selects.
module multicycle_ctrl #(
    parameter int DataBusBits = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DataBusBits-1:0] inst,
    input  logic                   inst_valid,
    output logic                   imem_req,
    output logic                   ir_we,
    output logic [2:0]             imm_sel,
    output logic                   alu_src_a,
    output logic                   alu_src_b,
    input  logic                   branch_taken,
    output logic                   dmem_req,
    output logic                   dmem_we,
    input  logic                   dmem_ready,
    output logic                   reg_we,
    output logic [1:0]             wb_sel,
    output logic                   pc_we,
    output logic [1:0]             pc_sel,
    output logic                   illegal,
    output logic [31:0]            instret,
    output logic [2:0]             state_o
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_S    = 3'd1;
    localparam logic [2:0] IMM_B    = 3'd2;
    localparam logic [2:0] IMM_U    = 3'd3;
    localparam logic [2:0] IMM_J    = 3'd4;
    localparam logic [2:0] IMM_NONE = 3'd7;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam int            CntW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [6:0]      opcode_q, opcode_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     instret_q, instret_d;
    logic            illegal_q, illegal_d;

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic is_load, is_store, is_imm, is_reg, is_legal;
    logic [2:0] imm_fmt;
    logic retire;
    logic unused_inst_hi;

    assign unused_inst_hi = ^inst[DataBusBits-1:7];

    assign is_lui    = (opcode_q == OP_LUI);
    assign is_auipc  = (opcode_q == OP_AUIPC);
    assign is_jal    = (opcode_q == OP_JAL);
    assign is_jalr   = (opcode_q == OP_JALR);
    assign is_branch = (opcode_q == OP_BRANCH);
    assign is_load   = (opcode_q == OP_LOAD);
    assign is_store  = (opcode_q == OP_STORE);
    assign is_imm    = (opcode_q == OP_IMM);
    assign is_reg    = (opcode_q == OP_REG);
    assign is_legal  = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                       is_load | is_store | is_imm | is_reg;

    always_comb begin
        imm_fmt = IMM_NONE;
        if (is_imm || is_load || is_jalr) imm_fmt = IMM_I;
        else if (is_store)                imm_fmt = IMM_S;
        else if (is_branch)               imm_fmt = IMM_B;
        else if (is_lui || is_auipc)      imm_fmt = IMM_U;
        else if (is_jal)                  imm_fmt = IMM_J;
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        cnt_d     = cnt_q;
        retire    = 1'b0;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        imm_sel   = IMM_NONE;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = WB_ALU;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;

        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (inst_valid) begin
                    ir_we    = 1'b1;
                    opcode_d = inst[6:0];
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                imm_sel = imm_fmt;
                state_d = is_legal ? EXEC : TRAP;
            end
            EXEC: begin
                imm_sel   = imm_fmt;
                alu_src_a = is_auipc | is_jal | is_branch;
                alu_src_b = ~is_reg;
                if (is_branch) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken ? PC_BRANCH : PC_PLUS4;
                    retire  = 1'b1;
                    state_d = FETCH;
                end else if (is_load || is_store) begin
                    cnt_d   = '0;
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                // ready on the final counted cycle still completes the access
                if (dmem_ready) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d = TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WB: begin
                reg_we  = 1'b1;
                wb_sel  = is_load ? WB_MEM : ((is_jal || is_jalr) ? WB_PC4 : WB_ALU);
                pc_we   = 1'b1;
                pc_sel  = (is_jal || is_jalr) ? PC_JUMP : PC_PLUS4;
                retire  = 1'b1;
                state_d = FETCH;
            end
            TRAP: state_d = TRAP;
            default: state_d = FETCH;
        endcase

        instret_d = retire ? instret_q + 32'd1 : instret_q;
        illegal_d = illegal_q | (state_d == TRAP);

        // hold every output low for as long as reset is asserted
        if (!rst_n) begin
            imem_req  = 1'b0;
            ir_we     = 1'b0;
            imm_sel   = 3'd0;
            alu_src_a = 1'b0;
            alu_src_b = 1'b0;
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            reg_we    = 1'b0;
            wb_sel    = 2'd0;
            pc_we     = 1'b0;
            pc_sel    = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            opcode_q  <= '0;
            cnt_q     <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            cnt_q     <= cnt_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
    assign instret = instret_q;
    assign state_o = state_q;

endmodule
